// File: rtl/tdm_demux8.sv
// Serial TDM frame demultiplexer: N slots per frame, marker-based framing, one-clock output latency.
// Optional macro TDM_DEMUX_SYNC_ERR_EN enables the sync_err framing-error pulse (tied to 0 otherwise).
module tdm_demux8 #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         din,
  input  logic         fsync,
  input  logic         en,
  output logic [N-1:0] dout,
  output logic         dout_valid,
  output logic         locked,
  output logic         sync_err
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [N-1:0]    shadow, shadow_nx;
  logic [N-1:0]    dout_nx;
  logic            valid_nx;

  // NOTE: every variable gets its hold value before any branch, so no path can infer a latch.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    shadow_nx = shadow;
    dout_nx   = dout;
    valid_nx  = 1'b0;
    if (en) begin
      unique case (state)
        HUNT: begin
          if (fsync) begin
            shadow_nx[0] = din;
            cnt_nx       = CW'(1);
            state_nx     = RUN;
          end
        end
        RUN: begin
          if (fsync) begin
            // On-time or early marker: either way this slot starts a new frame.
            shadow_nx[0] = din;
            cnt_nx       = CW'(1);
          end else if (cnt == '0) begin
            state_nx = HUNT;
          end else if (cnt == LAST) begin
            dout_nx  = {din, shadow[N-2:0]};
            valid_nx = 1'b1;
            cnt_nx   = '0;
          end else begin
            shadow_nx[cnt] = din;
            cnt_nx         = cnt + 1'b1;
          end
        end
        default: state_nx = HUNT;
      endcase
    end
  end

  // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      cnt        <= '0;
      // NOTE: the shadow frame buffer is cleared on reset so no stale partial frame survives it.
      shadow     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      shadow     <= shadow_nx;
      dout       <= dout_nx;
      dout_valid <= valid_nx;
    end
  end

  assign locked = (state == RUN);

`ifdef TDM_DEMUX_SYNC_ERR_EN
  logic err_nx;

  // Missing marker at slot 0, or a marker arriving mid-frame.
  assign err_nx = en && (state == RUN) && (fsync ? (cnt != '0) : (cnt == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_err <= 1'b0;
    end else begin
      sync_err <= err_nx;
    end
  end
`else
  assign sync_err = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux8.sv
// Directed bench for tdm_demux8: queue-based frame model checked every cycle plus literal expectations.
module tb_tdm_demux8;

  localparam int N = 8;

`ifdef TDM_DEMUX_SYNC_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, din, fsync, en;
  logic [N-1:0] dout;
  logic         dout_valid, locked, sync_err;

  tdm_demux8 #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .fsync      (fsync),
    .en         (en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame model: bits collected since the last marker; a frame completes after N bits.
  bit           m_synced;
  bit           m_got[$];
  logic [N-1:0] m_dout;
  logic         m_valid, m_err;

  always @(posedge clk) begin
    logic [N-1:0] frame;
    if (rst) begin
      m_synced = 1'b0;
      m_got.delete();
      m_dout  <= '0;
      m_valid <= 1'b0;
      m_err   <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      m_err   <= 1'b0;
      if (en) begin
        if (fsync) begin
          if (m_synced && m_got.size() != 0) m_err <= 1'b1;
          m_got.delete();
          m_got.push_back(din);
          m_synced = 1'b1;
        end else if (m_synced) begin
          if (m_got.size() == 0) begin
            m_err    <= 1'b1;
            m_synced = 1'b0;
          end else begin
            m_got.push_back(din);
            if (m_got.size() == N) begin
              for (int k = 0; k < N; k++) frame[k] = m_got[k];
              m_dout  <= frame;
              m_valid <= 1'b1;
              m_got.delete();
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      check("cmp_dout", dout, m_dout);
      check("cmp_dout_valid", dout_valid, m_valid);
      check("cmp_locked", locked, m_synced);
      check("cmp_sync_err", sync_err, ERR_ON & m_err);
    end
  end

  typedef struct {
    int           c;
    logic [N-1:0] d;
  } pulse_t;
  pulse_t plog[$];

  always @(negedge clk) begin
    pulse_t p;
    if (cyc > 0 && dout_valid === 1'b1) begin
      p.c = cyc;
      p.d = dout;
      plog.push_back(p);
    end
  end

  // Inputs for one cycle; returns 1 time unit after the edge that sampled them.
  task automatic drive(input logic e, input logic f, input logic d);
    en    = e;
    fsync = f;
    din   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_slots(input logic [N-1:0] v, input int lo, input int hi, input bit gap);
    for (int k = lo; k <= hi; k++) begin
      drive(1'b1, k == 0, v[k]);
      if (gap) drive(1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; fsync = 1'b0; din = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1);  // reset wins over an en/fsync slot
    check("rst_dout", dout, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_sync_err", sync_err, 0);
    rst = 1'b0;

    // Slots 0..7 = 1,0,1,1,0,0,1,0
    plog.delete();
    t0 = cyc;
    send_slots(8'b0100_1101, 0, N - 1, 1'b0);
    check("f1_valid", dout_valid, 1);
    check("f1_dout", dout, 8'h4D);
    check("f1_locked", locked, 1);
    drive(1'b0, 1'b0, 1'b0);
    check("f1_valid_drop", dout_valid, 0);
    check("f1_pulses", plog.size(), 1);
    if (plog.size() >= 1) check("f1_latency", plog[0].c, t0 + 8);

    // Back-to-back frames
    plog.delete();
    t0 = cyc;
    send_slots(8'hA5, 0, N - 1, 1'b0);
    send_slots(8'h3C, 0, N - 1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("b2b_pulses", plog.size(), 2);
    if (plog.size() == 2) begin
      check("b2b_first", plog[0].d, 8'hA5);
      check("b2b_second", plog[1].d, 8'h3C);
      check("b2b_first_cyc", plog[0].c, t0 + 8);
      check("b2b_spacing", plog[1].c - plog[0].c, 8);
    end

    // en toggling 1,0: slot 7 sits in cycle t0+14, pulse in t0+15 (16th cycle counting slot 0 as 1st)
    plog.delete();
    t0 = cyc;
    send_slots(8'hA5, 0, N - 1, 1'b1);
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    check("gap_pulses", plog.size(), 1);
    if (plog.size() >= 1) begin
      check("gap_dout", plog[0].d, 8'hA5);
      check("gap_cyc", plog[0].c, t0 + 15);
    end

    // Early marker in place of slot N-1: resync wins, no frame output
    plog.delete();
    send_slots(8'hFF, 0, N - 2, 1'b0);
    send_slots(8'h81, 0, 0, 1'b0);
    check("late_valid", dout_valid, 0);
    check("late_sync_err", sync_err, ERR_ON);
    check("late_dout", dout, 8'hA5);
    send_slots(8'h81, 1, N - 1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("late_pulses", plog.size(), 1);
    if (plog.size() >= 1) check("late_frame", plog[0].d, 8'h81);

    // Early marker at slot 4
    plog.delete();
    send_slots(8'hFF, 0, 3, 1'b0);
    t0 = cyc;
    send_slots(8'h96, 0, 0, 1'b0);
    check("early_sync_err", sync_err, ERR_ON);
    check("early_valid", dout_valid, 0);
    check("early_locked", locked, 1);
    send_slots(8'h96, 1, 1, 1'b0);
    check("early_err_one_cycle", sync_err, 0);
    send_slots(8'h96, 2, N - 1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("early_pulses", plog.size(), 1);
    if (plog.size() >= 1) begin
      check("early_frame", plog[0].d, 8'h96);
      check("early_cyc", plog[0].c, t0 + 8);
    end

    // Missing marker after a valid frame, then relock
    drive(1'b1, 1'b0, 1'b1);
    check("miss_locked", locked, 0);
    check("miss_dout", dout, 8'h96);
    check("miss_sync_err", sync_err, ERR_ON);
    check("miss_valid", dout_valid, 0);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    check("hunt_locked", locked, 0);
    check("hunt_sync_err", sync_err, 0);
    plog.delete();
    send_slots(8'h5A, 0, 0, 1'b0);
    check("relock_locked", locked, 1);
    send_slots(8'h5A, 1, N - 1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("relock_pulses", plog.size(), 1);
    if (plog.size() >= 1) check("relock_frame", plog[0].d, 8'h5A);

    // Reset at slot 5
    plog.delete();
    send_slots(8'hC3, 0, 4, 1'b0);
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    check("mrst_dout", dout, 0);
    check("mrst_valid", dout_valid, 0);
    check("mrst_locked", locked, 0);
    check("mrst_sync_err", sync_err, 0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    check("mrst_hunt", locked, 0);
    check("mrst_pulses", plog.size(), 0);
    send_slots(8'h3C, 0, N - 1, 1'b0);
    check("post_rst_frame", dout, 8'h3C);
    check("post_rst_valid", dout_valid, 1);
    drive(1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdm_demux8.md
TDM_DEMUX8 -- requirements
Module: tdm_demux8

Interface
REQ-001 The block SHALL have parameter N, default 8, the number of TDM slots and output lanes per frame (legal 2..16).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 The block SHALL have port din, input, 1, the serial TDM data bit for the current slot.
REQ-005 The block SHALL have port fsync, input, 1, the frame marker, high during slot 0 of each frame.
REQ-006 The block SHALL have port en, input, 1, the slot strobe; din and fsync are sampled only when en=1.
REQ-007 The block SHALL have port dout, output, N, the last completed frame, where dout[k] is the bit received in slot k.
REQ-008 The block SHALL have port dout_valid, output, 1, a one-cycle pulse marking an update of dout.
REQ-009 The block SHALL have port locked, output, 1, high while the state is RUN.
REQ-010 The block SHALL have port sync_err, output, 1, a one-cycle framing-error pulse (see Configuration).

Function
REQ-011 The block SHALL implement the states HUNT and RUN, a slot counter cnt of width clog2(N), and an N-bit shadow register.
REQ-012 With en=0 in any cycle, the block SHALL hold all state, and dout_valid and sync_err SHALL be 0 in the following cycle.
REQ-013 In HUNT with en=1 and fsync=0, the block SHALL discard din and remain in HUNT.
REQ-014 In HUNT with en=1 and fsync=1, the block SHALL write din to shadow[0], set cnt=1 and enter RUN.
REQ-015 In RUN with en=1 and 0<cnt<N-1 and fsync=0, the block SHALL write din to shadow[cnt] and increment cnt.
REQ-016 In RUN with en=1 and cnt=N-1 and fsync=0, the block SHALL write the frame to dout (shadow bits 0..N-2 plus din in bit N-1), pulse dout_valid in the next cycle, and set cnt=0.
REQ-017 Latency SHALL be one clock: dout and dout_valid become valid in the cycle after the en cycle that carries slot N-1.
REQ-018 In RUN with en=1 and cnt=0 and fsync=1, the block SHALL write din to shadow[0] and set cnt=1, giving back-to-back frames with no gap.
REQ-019 In RUN with en=1 and cnt=0 and fsync=0 (missing marker), the block SHALL discard din, enter HUNT and leave dout unchanged.
REQ-020 In RUN with en=1 and cnt≠0 and fsync=1 (early marker), the block SHALL discard the partial frame, treat the slot as slot 0 (write shadow[0], set cnt=1) and stay in RUN.
REQ-021 When an early marker coincides with cnt=N-1, the block SHALL let the resync take priority: no dout update and no dout_valid.
REQ-022 dout SHALL hold its value between dout_valid pulses, and partial frames SHALL never be visible on dout.
REQ-023 cnt SHALL never exceed N-1, and it wraps to 0 only as specified above.

Reset
REQ-024 With rst=1 at a clock edge, the block SHALL set state=HUNT, cnt=0, shadow=0, dout=0, dout_valid=0, locked=0 and sync_err=0.
REQ-025 rst SHALL take priority over en, and a reset mid-frame SHALL discard the partial frame with no dout_valid.

Configuration
REQ-026 With macro TDM_DEMUX_SYNC_ERR_EN defined, the block SHALL pulse sync_err for one cycle in the cycle after each missing-marker (REQ-019) or early-marker (REQ-020) event.
REQ-027 With TDM_DEMUX_SYNC_ERR_EN undefined, the block SHALL keep the sync_err port and tie it to 0, with recovery behaviour unchanged.

Verification
REQ-028 The bench SHALL apply reset, then with en=1 every cycle and fsync on slot 0, send din slots 0..7 = 1,0,1,1,0,0,1,0, and SHALL require dout=8'b01001101 with a single dout_valid pulse one cycle after slot 7 and locked=1.
REQ-029 The bench SHALL send two back-to-back frames, 8'hA5 then 8'h3C, and SHALL require two dout_valid pulses exactly 8 cycles apart with dout=A5 then 3C.
REQ-030 The bench SHALL send the 8'hA5 frame with en toggling 1,0,1,0 and SHALL require the same dout=A5 with dout_valid 16 cycles after the first slot and no extra pulses.
REQ-031 The bench SHALL assert fsync at slot 4 mid-frame and SHALL require no dout_valid for the partial frame, a new frame counted from that slot, and (macro on) sync_err=1 for one cycle.
REQ-032 The bench SHALL drop fsync at the slot 0 following a valid frame and SHALL require locked=0 next cycle, dout unchanged, sync_err pulse (macro on) or 0 (macro off), and relock on the next fsync.
REQ-033 The bench SHALL assert rst at slot 5 of a frame and SHALL require all outputs 0 the next cycle, no dout_valid, and the state HUNT.
